// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : dmem_ctrl_pkg                                                     |
// | Purpose : Shared size codes, FSM state encoding and lane-mask helpers for   |
// |           the data-memory controller and its load aligner.                 |
// | Config  : DMEM_MISALIGNED_SPLIT_EN (used by dmem_ctrl, not by this package) |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
package dmem_ctrl_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC0 = 2'd1,
      ST_ACC1 = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // Byte-enable mask over a two-word window: bits [3:0] hit the addressed
   // word, bits [7:4] spill into the following word.
   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'h00;
      endcase
      return base << offset;
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
      return ((size == SZ_H) && offset[0]) || ((size == SZ_W) && (offset != 2'b00));
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ctrl_load_align.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : dmem_load_align                                                   |
// | Purpose : Combinational load aligner. Shifts a 64-bit two-word window right |
// |           by the byte offset, selects byte/half/word and sign- or zero-     |
// |           extends it. Shared with the instruction fetch path.               |
// | Ports   : win_i      64-bit window {next word, addressed word}              |
// |           offset_i   byte offset within the addressed word                  |
// |           size_i     SZ_B / SZ_H / SZ_W (SZ_X yields 0)                     |
// |           unsigned_i zero-extend when 1                                     |
// |           data_o     extended 32-bit result                                 |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module dmem_load_align
   import dmem_ctrl_pkg::*;
(
   input  logic [63:0] win_i,
   input  logic [1:0]  offset_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] w_shifted;

   always_comb begin
      w_shifted = 32'(win_i >> {offset_i, 3'b000});
      case (size_i)
         SZ_B:    data_o = {{24{~unsigned_i & w_shifted[7]}},  w_shifted[7:0]};
         SZ_H:    data_o = {{16{~unsigned_i & w_shifted[15]}}, w_shifted[15:0]};
         SZ_W:    data_o = w_shifted;
         default: data_o = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/dmem_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : dmem_ctrl                                                         |
// | Purpose : Data-memory controller between the load/store stage and four     |
// |           byte-wide BRAM lanes. One request per handshake, single-cycle    |
// |           response strobe, sign/zero-extended load data.                   |
// | Config  : DMEM_MISALIGNED_SPLIT_EN - when defined, misaligned accesses are  |
// |           split over two words (ACC0 then ACC1); otherwise they return an  |
// |           error without touching memory.                                   |
// | Ports   : CLK, RST (sync, active-high)                                      |
// |           REQ_VALID/REQ_READY handshake; REQ_WE, REQ_SIZE, REQ_UNSIGNED,    |
// |           REQ_ADDR, REQ_WDATA request fields                                |
// |           RSP_VALID strobe with RSP_RDATA / RSP_ERR                         |
// |           MEM_W_ADDR/MEM_R_ADDR word-aligned lane address, MEM_WE/MEM_RE   |
// |           per-lane enables, MEM_DIN lane write data, MEM_DOUT lane data    |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 13
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_WE,
   input  logic [1:0]            REQ_SIZE,
   input  logic                  REQ_UNSIGNED,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [31:0]           REQ_WDATA,
   output logic                  RSP_VALID,
   output logic [31:0]           RSP_RDATA,
   output logic                  RSP_ERR,
   output logic [ADDR_WIDTH-1:0] MEM_W_ADDR,
   output logic [ADDR_WIDTH-1:0] MEM_R_ADDR,
   output logic [3:0]            MEM_WE,
   output logic [3:0]            MEM_RE,
   output logic [31:0]           MEM_DIN,
   input  logic [31:0]           MEM_DOUT
);

   state_t                state_q, state_d;
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [31:0]           wdata_q;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;

   logic                  w_accept;
   logic                  w_req_bad;
   logic [ADDR_WIDTH-3:0] w_word;
   logic [3:0]            w_mask0;
   logic [31:0]           w_din0;
   logic [63:0]           w_win;
   logic [31:0]           w_load;
   logic [3:0]            w_we;
   logic [3:0]            w_re;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [31:0]           w_din;

`ifdef DMEM_MISALIGNED_SPLIT_EN
   logic [31:0]           word0_q;
   logic                  w_split;
   logic [3:0]            w_mask1;
   logic [31:0]           w_din1;
   logic [ADDR_WIDTH-3:0] w_word_nx;
`endif

   assign w_accept = (state_q == ST_IDLE) && REQ_VALID;
   assign w_word   = addr_q[ADDR_WIDTH-1:2];
   assign w_mask0  = 4'(lane_mask(size_q, addr_q[1:0]));
   assign w_din0   = wdata_q << {addr_q[1:0], 3'b000};

`ifdef DMEM_MISALIGNED_SPLIT_EN
   assign w_req_bad = (REQ_SIZE == SZ_X);
   assign w_split   = misaligned(size_q, addr_q[1:0]);
   assign w_mask1   = 4'(lane_mask(size_q, addr_q[1:0]) >> 4);
   assign w_din1    = 32'(({32'h0, wdata_q} << {addr_q[1:0], 3'b000}) >> 32);
   // Word index wraps naturally at the top of the lane address space.
   assign w_word_nx = w_word + (ADDR_WIDTH-2)'(1);
   assign w_win     = (state_q == ST_ACC1) ? {MEM_DOUT, word0_q} : {32'h0, MEM_DOUT};
`else
   assign w_req_bad = (REQ_SIZE == SZ_X) || misaligned(REQ_SIZE, REQ_ADDR[1:0]);
   assign w_win     = {32'h0, MEM_DOUT};
`endif

   dmem_load_align u_align (
      .win_i      (w_win),
      .offset_i   (addr_q[1:0]),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (w_load)
   );

   always_comb begin
      state_d     = state_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      w_we        = 4'h0;
      w_re        = 4'h0;
      w_addr      = '0;
      w_din       = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (REQ_VALID) begin
               if (w_req_bad) begin
                  // Rejected requests never touch the lanes.
                  state_d     = ST_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = 32'h0;
               end else begin
                  state_d = ST_ACC0;
               end
            end
         end
         ST_ACC0: begin
            w_addr = {w_word, 2'b00};
            if (we_q) begin
               w_we  = w_mask0;
               w_din = w_din0;
            end else begin
               w_re = 4'hF;
            end
`ifdef DMEM_MISALIGNED_SPLIT_EN
            if (w_split) state_d = ST_ACC1;
            else
`endif
            begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = we_q ? 32'h0 : w_load;
            end
         end
`ifdef DMEM_MISALIGNED_SPLIT_EN
         ST_ACC1: begin
            w_addr = {w_word_nx, 2'b00};
            if (we_q) begin
               w_we  = w_mask1;
               w_din = w_din1;
            end else begin
               w_re = w_mask1;
            end
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = we_q ? 32'h0 : w_load;
         end
`endif
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         we_q        <= 1'b0;
         size_q      <= SZ_B;
         uns_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
`ifdef DMEM_MISALIGNED_SPLIT_EN
         word0_q     <= 32'h0;
`endif
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         if (w_accept) begin
            we_q    <= REQ_WE;
            size_q  <= REQ_SIZE;
            uns_q   <= REQ_UNSIGNED;
            addr_q  <= REQ_ADDR;
            wdata_q <= REQ_WDATA;
         end
`ifdef DMEM_MISALIGNED_SPLIT_EN
         if (state_q == ST_ACC0) word0_q <= MEM_DOUT;
`endif
      end
   end

   assign REQ_READY  = (state_q == ST_IDLE);
   assign RSP_VALID  = rsp_valid_q;
   assign RSP_ERR    = rsp_err_q;
   assign RSP_RDATA  = rsp_rdata_q;
   assign MEM_W_ADDR = w_addr;
   assign MEM_R_ADDR = w_addr;
   assign MEM_DIN    = w_din;
   // Lanes act on the negedge, so gating with the live reset suppresses any
   // write or read in a cycle where reset is high.
   assign MEM_WE     = w_we & {4{~RST}};
   assign MEM_RE     = w_re & {4{~RST}};

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module  : tb_dmem_ctrl                                                      |
// | Purpose : Self-checking bench for dmem_ctrl. Models four negedge BRAM lanes |
// |           and keeps a byte-array reference memory; expected responses are  |
// |           queued at issue time and popped by an independent monitor.       |
// | Config  : follows DMEM_MISALIGNED_SPLIT_EN like the design                  |
// | Revision: 1.0 - initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_dmem_ctrl;

   localparam int AW     = 13;
   localparam int NBYTES = 1 << AW;
   localparam int NWORDS = NBYTES / 4;
`ifdef DMEM_MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          REQ_VALID = 1'b0;
   logic          REQ_READY;
   logic          REQ_WE = 1'b0;
   logic [1:0]    REQ_SIZE = 2'b00;
   logic          REQ_UNSIGNED = 1'b0;
   logic [AW-1:0] REQ_ADDR = '0;
   logic [31:0]   REQ_WDATA = 32'h0;
   logic          RSP_VALID;
   logic [31:0]   RSP_RDATA;
   logic          RSP_ERR;
   logic [AW-1:0] MEM_W_ADDR;
   logic [AW-1:0] MEM_R_ADDR;
   logic [3:0]    MEM_WE;
   logic [3:0]    MEM_RE;
   logic [31:0]   MEM_DIN;
   logic [31:0]   MEM_DOUT;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sbq[$];
   exp_t mon_e;

   logic [7:0] lane_mem [4][NWORDS];
   logic [7:0] ref_mem  [NBYTES];
   logic [31:0] dout_q = 32'h0;
   logic [3:0]  we_hist [4096];
   logic [3:0]  re_hist [4096];

   always #5 CLK = ~CLK;

   dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .REQ_VALID    (REQ_VALID),
      .REQ_READY    (REQ_READY),
      .REQ_WE       (REQ_WE),
      .REQ_SIZE     (REQ_SIZE),
      .REQ_UNSIGNED (REQ_UNSIGNED),
      .REQ_ADDR     (REQ_ADDR),
      .REQ_WDATA    (REQ_WDATA),
      .RSP_VALID    (RSP_VALID),
      .RSP_RDATA    (RSP_RDATA),
      .RSP_ERR      (RSP_ERR),
      .MEM_W_ADDR   (MEM_W_ADDR),
      .MEM_R_ADDR   (MEM_R_ADDR),
      .MEM_WE       (MEM_WE),
      .MEM_RE       (MEM_RE),
      .MEM_DIN      (MEM_DIN),
      .MEM_DOUT     (MEM_DOUT)
   );

   assign MEM_DOUT = dout_q;

   always @(posedge CLK) cyc <= cyc + 1;

   // Byte-wide lanes acting on the falling edge.
   always @(negedge CLK) begin
      for (int i = 0; i < 4; i++) begin
         if (MEM_WE[i]) lane_mem[i][MEM_W_ADDR[AW-1:2]] <= MEM_DIN[8*i +: 8];
         if (MEM_RE[i]) dout_q[8*i +: 8] <= lane_mem[i][MEM_R_ADDR[AW-1:2]];
      end
      we_hist[cyc % 4096] <= MEM_WE;
      re_hist[cyc % 4096] <= MEM_RE;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor: every response strobe must match the oldest outstanding expectation.
   always @(posedge CLK) begin
      #1;
      if (RSP_VALID) begin
         if (sbq.size() == 0) begin
            check("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            mon_e = sbq.pop_front();
            check("rsp_rdata", RSP_RDATA, mon_e.rdata);
            check("rsp_err", {31'h0, RSP_ERR}, {31'h0, mon_e.err});
            check("rsp_latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
         end
      end
   end

   // Reference behaviour from the access rules, on a flat byte array.
   function automatic exp_t ref_access(input bit we, input logic [1:0] sz, input bit uns,
                                       input int addr, input logic [31:0] wd);
      exp_t e;
      int n;
      bit mis;
      logic [31:0] v;
      e = '0;
      n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = ((sz == 2'd1) && (addr % 2 != 0)) || ((sz == 2'd2) && (addr % 4 != 0));
      if (sz == 2'd3 || (mis && !SPLIT)) begin
         e.err = 1'b1;
         e.lat = 0;
         return e;
      end
      e.lat = mis ? 2 : 1;
      if (we) begin
         for (int k = 0; k < n; k++) ref_mem[(addr + k) % NBYTES] = wd[8*k +: 8];
      end else begin
         v = 32'h0;
         for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(addr + k) % NBYTES]) << (8 * k));
         if (!uns && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
         if (!uns && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
         e.rdata = v;
      end
      return e;
   endfunction

   task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input int addr,
                        input logic [31:0] wd, output int acc);
      exp_t e;
      int n;
      REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = sz; REQ_UNSIGNED = uns;
      REQ_ADDR = AW'(addr); REQ_WDATA = wd;
      n = 0;
      while (!REQ_READY && n < 50) begin
         @(posedge CLK); #1; n++;
      end
      if (!REQ_READY) begin
         check("req_ready_timeout", 32'd0, 32'd1);
         REQ_VALID = 1'b0;
         acc = 0;
         return;
      end
      e = ref_access(we, sz, uns, addr, wd);
      e.acc = cyc + 1;
      sbq.push_back(e);
      acc = e.acc;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 20) begin
         @(posedge CLK); #2; n++;
      end
      if (sbq.size() != 0) begin
         check("rsp_timeout", 32'(sbq.size()), 32'd0);
         sbq.delete();
      end
   endtask

   task automatic op(input bit we, input logic [1:0] sz, input bit uns, input int addr,
                     input logic [31:0] wd, output int acc);
      issue(we, sz, uns, addr, wd, acc);
      wait_done();
   endtask

   function automatic logic [3:0] seen_re(input int acc, input int n);
      logic [3:0] m;
      m = 4'h0;
      for (int k = 0; k < n; k++) m = m | re_hist[(acc + k) % 4096];
      return m;
   endfunction

   function automatic logic [3:0] seen_we(input int acc, input int n);
      logic [3:0] m;
      m = 4'h0;
      for (int k = 0; k < n; k++) m = m | we_hist[(acc + k) % 4096];
      return m;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      int accepts;
      int addr;
      int r;
      logic [1:0] sz;
      logic [31:0] word_now;

      for (int w = 0; w < NWORDS; w++)
         for (int i = 0; i < 4; i++) lane_mem[i][w] = 8'h00;
      for (int b = 0; b < NBYTES; b++) ref_mem[b] = 8'h00;
      for (int i = 0; i < 4096; i++) begin
         we_hist[i] = 4'h0;
         re_hist[i] = 4'h0;
      end

      RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;

      // Reset state.
      check("rst_ready", {31'h0, REQ_READY}, 32'd1);
      check("rst_rsp", {RSP_RDATA[29:0], RSP_VALID, RSP_ERR}, 32'd0);
      check("rst_mem_en", {24'h0, MEM_WE, MEM_RE}, 32'd0);
      check("rst_mem_din", MEM_DIN, 32'd0);
      check("rst_mem_addr", {3'b0, MEM_W_ADDR, 3'b0, MEM_R_ADDR}, 32'd0);

      // Word store / load.
      op(1'b1, 2'b10, 1'b0, 'h010, 32'hDEAD_BEEF, acc);
      check("sw_we_acc0", {28'h0, we_hist[acc % 4096]}, 32'hF);
      op(1'b0, 2'b10, 1'b0, 'h010, 32'h0, acc);
      check("lw_re_acc0", {28'h0, re_hist[acc % 4096]}, 32'hF);

      // Byte store / signed and unsigned byte loads.
      op(1'b1, 2'b00, 1'b0, 'h013, 32'h0000_0080, acc);
      check("sb_we_acc0", {28'h0, we_hist[acc % 4096]}, 32'h8);
      op(1'b0, 2'b00, 1'b0, 'h013, 32'h0, acc);
      op(1'b0, 2'b00, 1'b1, 'h013, 32'h0, acc);

      // Half store / load; half at word base after a word store.
      op(1'b1, 2'b01, 1'b0, 'h006, 32'h0000_1234, acc);
      check("sh_we_acc0", {28'h0, we_hist[acc % 4096]}, 32'hC);
      op(1'b0, 2'b01, 1'b0, 'h006, 32'h0, acc);
      op(1'b1, 2'b10, 1'b0, 'h004, 32'h8000_0000, acc);
      op(1'b0, 2'b01, 1'b0, 'h004, 32'h0, acc);

      // Misaligned word load across 0x010/0x014.
      op(1'b1, 2'b10, 1'b0, 'h010, 32'h4433_2211, acc);
      op(1'b1, 2'b10, 1'b0, 'h014, 32'h8877_6655, acc);
      op(1'b0, 2'b10, 1'b0, 'h011, 32'h0, acc);
      if (SPLIT) begin
         check("split_re_acc0", {28'h0, re_hist[acc % 4096]}, 32'hF);
         check("split_re_acc1", {28'h0, re_hist[(acc + 1) % 4096]}, 32'h1);
      end else begin
         check("misaligned_no_re", {28'h0, seen_re(acc, 3)}, 32'h0);
      end

      // Illegal size.
      op(1'b1, 2'b11, 1'b0, 'h020, 32'hFFFF_FFFF, acc);
      check("illegal_no_we", {28'h0, seen_we(acc, 3)}, 32'h0);

      // Reset in ACC0 of a store: no write, no response, idle afterwards.
      REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_UNSIGNED = 1'b0;
      REQ_ADDR = AW'('h020); REQ_WDATA = 32'hCAFE_F00D;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      RST = 1'b1;
      #1;
      check("rst_acc0_we", {28'h0, MEM_WE}, 32'h0);
      @(posedge CLK); #1;
      RST = 1'b0;
      check("rst_acc0_ready", {31'h0, REQ_READY}, 32'd1);
      check("rst_acc0_rsp", {31'h0, RSP_VALID}, 32'd0);
      word_now = {lane_mem[3][8], lane_mem[2][8], lane_mem[1][8], lane_mem[0][8]};
      check("rst_acc0_mem", word_now,
            {ref_mem['h23], ref_mem['h22], ref_mem['h21], ref_mem['h20]});
      repeat (3) @(posedge CLK);
      #1;

      // REQ_VALID held high: one accept every three cycles.
      accepts = 0;
      REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_UNSIGNED = 1'b0;
      REQ_ADDR = AW'('h010); REQ_WDATA = 32'h0;
      for (int i = 0; i < 9; i++) begin
         if (i == 1) check("b2b_ready_acc0", {31'h0, REQ_READY}, 32'd0);
         if (i == 2) check("b2b_ready_resp", {31'h0, REQ_READY}, 32'd0);
         if (REQ_READY) begin
            mon_e = ref_access(1'b0, 2'b10, 1'b0, 'h010, 32'h0);
            mon_e.acc = cyc + 1;
            sbq.push_back(mon_e);
            accepts++;
         end
         @(posedge CLK); #1;
      end
      REQ_VALID = 1'b0;
      check("b2b_accepts", 32'(accepts), 32'd3);
      wait_done();

      // Randomised traffic, including the wrap-around region.
      for (int t = 0; t < 200; t++) begin
         r  = int'($urandom_range(0, 7));
         sz = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
         if ($urandom_range(0, 3) == 0) addr = NBYTES - 8 + int'($urandom_range(0, 7));
         else                           addr = int'($urandom_range(0, 63));
         op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, acc);
      end

      wait_done();
      @(posedge CLK); #2;
      check("sb_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
